// File: rtl/mc_controller_if.sv
// -----------------------------------------------------------------------------
// mc_controller_if
// Bundles the instruction fields and status coming from the multicycle MIPS
// datapath together with every control line the main controller drives back.
//
// Signals:
//   op, funct, zero      datapath -> controller (instr[31:26], instr[5:0], ALU zero)
//   pcen, iord, irwrite, memwrite, memtoreg, res_zeroextimm, regdst, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol, illegal, state
//                        controller -> datapath (selects, enables, debug state)
//
// Modports:
//   master : datapath side (drives op/funct/zero, consumes control)
//   slave  : controller side (consumes op/funct/zero, drives control)
// -----------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       memtoreg;
  logic       res_zeroextimm;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct, zero,
    input  pcen, iord, irwrite, memwrite, memtoreg, res_zeroextimm, regdst,
           regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    input  op, funct, zero,
    output pcen, iord, irwrite, memwrite, memtoreg, res_zeroextimm, regdst,
           regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Main controller of the multicycle MIPS datapath: a Moore FSM stepping each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK (3 to 5 cycles) plus
// the ALU decoder that turns funct into the 4-bit alucontrol.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; forces FETCH and holds the write-type
//          enables (pcen, irwrite, memwrite, regwrite, illegal) at 0
//   bus    mc_controller_if.slave: op/funct/zero in, control lines and debug
//          state out
//
// Parameter:
//   RESET_STATE  state entered on reset (FETCH encoding)
//
// Build option:
//   MC_CTRL_ILLEGAL_TRAP_EN  when defined, an unknown opcode goes to ILLEGAL
//   and raises illegal for one cycle; otherwise it retires as a 2-cycle NOP
//   and illegal is tied to 0.
// -----------------------------------------------------------------------------
module mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_LIWB    = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LI   = 6'b001111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_iord;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_memtoreg;
  logic       w_zeroext;
  logic       w_regdst;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [3:0] w_alucontrol;
  logic       w_illegal;

  // R-type funct decode; unknown functs fall back to ADD so the instruction
  // still retires normally.
  function automatic logic [3:0] alu_decode(input logic [5:0] funct);
    case (funct)
      6'b100000: alu_decode = ALU_ADD;
      6'b100010: alu_decode = ALU_SUB;
      6'b100100: alu_decode = ALU_AND;
      6'b100101: alu_decode = ALU_OR;
      6'b101010: alu_decode = ALU_SLT;
      6'b000000: alu_decode = ALU_SLL;
      default:   alu_decode = ALU_ADD;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          OP_LI:        w_next = S_LIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      w_next = S_ILLEGAL;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMRD:   w_next = S_MEMWB;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore control decode from the current state.
  always_comb begin
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_iord       = 1'b0;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_memtoreg   = 1'b0;
    w_zeroext    = 1'b0;
    w_regdst     = 1'b0;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = ALU_ADD;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE:  w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD:   w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = alu_decode(bus.funct);
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = 2'b01;
        w_branch     = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_LIWB: begin
        w_zeroext  = 1'b1;
        w_regwrite = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        w_illegal = 1'b1;
`else
        w_illegal = 1'b0;
`endif
      end
      default: w_illegal = 1'b0;
    endcase
  end

  // Write-type enables are masked by reset so an aborted instruction cannot
  // commit anything while reset is high.
  assign bus.pcen           = ~reset & (w_pcwrite | (w_branch & bus.zero));
  assign bus.irwrite        = ~reset & w_irwrite;
  assign bus.memwrite       = ~reset & w_memwrite;
  assign bus.regwrite       = ~reset & w_regwrite;
  assign bus.illegal        = ~reset & w_illegal;
  assign bus.iord           = w_iord;
  assign bus.memtoreg       = w_memtoreg;
  assign bus.res_zeroextimm = w_zeroext;
  assign bus.regdst         = w_regdst;
  assign bus.alusrca        = w_alusrca;
  assign bus.alusrcb        = w_alusrcb;
  assign bus.pcsrc          = w_pcsrc;
  assign bus.alucontrol     = w_alucontrol;
  assign bus.state          = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Self-checking bench for mc_controller. An instruction-level model expands
// each opcode into the list of per-cycle control expectations it should
// produce; directed cases cover reset, LW, SLT, BEQ taken/not taken, LI, an
// unknown opcode and a reset abort in MEMWR, followed by random instructions.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       zext;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alu;
    logic       ill;
  } rec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  rec_t q[$];

  mc_controller_if bus ();

  mc_controller #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b1000;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic rec_t blank(input logic [3:0] st);
    rec_t r;
    r     = '0;
    r.st  = st;
    r.alu = 4'b0010;
    return r;
  endfunction

  // Expected outputs while reset is held: FETCH selects, enables forced low.
  function automatic rec_t reset_rec();
    rec_t r;
    r         = blank(4'd0);
    r.alusrcb = 2'b01;
    return r;
  endfunction

  // Expand one instruction into its per-cycle expectations.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] funct);
    rec_t r;
    r = blank(4'd0); r.irwrite = 1'b1; r.alusrcb = 2'b01; r.pcwrite = 1'b1; q.push_back(r);
    r = blank(4'd1); r.alusrcb = 2'b11; q.push_back(r);
    case (op)
      6'b100011: begin
        r = blank(4'd2); r.alusrca = 1'b1; r.alusrcb = 2'b10; q.push_back(r);
        r = blank(4'd3); r.iord = 1'b1; q.push_back(r);
        r = blank(4'd4); r.memtoreg = 1'b1; r.regwrite = 1'b1; q.push_back(r);
      end
      6'b101011: begin
        r = blank(4'd2); r.alusrca = 1'b1; r.alusrcb = 2'b10; q.push_back(r);
        r = blank(4'd5); r.iord = 1'b1; r.memwrite = 1'b1; q.push_back(r);
      end
      6'b000000: begin
        r = blank(4'd6); r.alusrca = 1'b1; r.alu = alu_of(funct); q.push_back(r);
        r = blank(4'd7); r.regdst = 1'b1; r.regwrite = 1'b1; q.push_back(r);
      end
      6'b000100: begin
        r = blank(4'd8); r.alusrca = 1'b1; r.alu = 4'b0110; r.pcsrc = 2'b01;
        r.branch = 1'b1; q.push_back(r);
      end
      6'b001000: begin
        r = blank(4'd9); r.alusrca = 1'b1; r.alusrcb = 2'b10; q.push_back(r);
        r = blank(4'd10); r.regwrite = 1'b1; q.push_back(r);
      end
      6'b000010: begin
        r = blank(4'd11); r.pcsrc = 2'b10; r.pcwrite = 1'b1; q.push_back(r);
      end
      6'b001111: begin
        r = blank(4'd12); r.zext = 1'b1; r.regwrite = 1'b1; q.push_back(r);
      end
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        r = blank(4'd13); r.ill = 1'b1; q.push_back(r);
`endif
      end
    endcase
  endtask

  task automatic compare(input string tag, input rec_t r);
    logic [17:0] obs;
    logic [17:0] exp;
    logic        pcen_e;
    pcen_e = r.pcwrite | (r.branch & bus.zero);
    obs = {bus.pcen, bus.iord, bus.irwrite, bus.memwrite, bus.memtoreg,
           bus.res_zeroextimm, bus.regdst, bus.regwrite, bus.alusrca,
           bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
    exp = {pcen_e, r.iord, r.irwrite, r.memwrite, r.memtoreg, r.zext,
           r.regdst, r.regwrite, r.alusrca, r.alusrcb, r.pcsrc, r.alu, r.ill};
    check({tag, "_state"}, {28'd0, bus.state}, {28'd0, r.st});
    check({tag, "_ctrl"}, {14'd0, obs}, {14'd0, exp});
  endtask

  // zmode: 0/1 force zero, 2 random each cycle. abort_at >= 0 asserts reset
  // right after that cycle's check.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                           input int zmode, input int abort_at);
    q.delete();
    push_instr(op, funct);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.op    = op;
        bus.funct = funct;
      end
      if (zmode == 2) bus.zero = 1'($urandom_range(0, 1));
      else            bus.zero = (zmode == 1);
      #1;
      compare(tag, q[k]);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        compare({tag, "_abort"}, reset_rec());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        break;
      end
    end
  endtask

  logic [5:0] legal_ops [0:6];
  logic [5:0] functs [0:5];

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    total = 0;
    bad   = 0;
    legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011; legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100; legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;
    legal_ops[6] = 6'b001111;
    functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
    functs[3] = 6'b100101; functs[4] = 6'b101010; functs[5] = 6'b000000;

    reset     = 1'b1;
    bus.op    = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      compare("reset", reset_rec());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr("lw",     6'b100011, 6'b000000, 2, -1);
    run_instr("slt",    6'b000000, 6'b101010, 2, -1);
    run_instr("beq_t",  6'b000100, 6'b000000, 1, -1);
    run_instr("beq_nt", 6'b000100, 6'b000000, 0, -1);
    run_instr("li",     6'b001111, 6'b000000, 2, -1);
    run_instr("badop",  6'b111111, 6'b000000, 2, -1);
    run_instr("lw2",    6'b100011, 6'b100000, 2, -1);
    run_instr("sw_rst", 6'b101011, 6'b000000, 2, 3);
    run_instr("addi",   6'b001000, 6'b000000, 2, -1);
    run_instr("j",      6'b000010, 6'b000000, 2, -1);
    run_instr("r_unk",  6'b000000, 6'b111111, 2, -1);

    for (int n = 0; n < 200; n++) begin
      int idx;
      idx = int'($urandom_range(0, 7));
      if (idx == 7) rop = 6'($urandom);
      else          rop = legal_ops[idx];
      if ($urandom_range(0, 1) == 0) rfn = functs[$urandom_range(0, 5)];
      else                           rfn = 6'($urandom);
      run_instr("rand", rop, rfn, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
